// File: rtl/sigan_multi.sv
// sigan_multi: multi-channel start/stop gated signature analyzer.
// One gate FSM drives CHANNELS parallel LFSR compressors and a shared window clock counter.
module sigan_multi #(
    parameter int                WIDTH    = 16,
    parameter logic [WIDTH-1:0]  TAPS     = 16'h8940,
    parameter int                CHANNELS = 4,
    parameter int                CNT_W    = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clk_en,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      start_inv,
    input  logic                      stop_inv,
    input  logic                      hold,
    input  logic                      rearm,
    input  logic [CHANNELS-1:0]       data,
    output logic [CHANNELS*WIDTH-1:0] signature,
    output logic [CNT_W-1:0]          count,
    output logic                      valid,
    output logic [CHANNELS-1:0]       unstable,
    output logic                      gate
);

    typedef enum logic [2:0] {IDLE, ARMED, RUN_W, RUN, HELD} state_t;

    state_t                    state_reg, state_next;
    logic                      s_lvl, p_lvl, running, window_end;
    logic [CNT_W-1:0]          cnt_reg, cnt_inc, count_reg;
    logic [CHANNELS*WIDTH-1:0] lfsr_reg, lfsr_shift, sig_reg;
    logic [CHANNELS-1:0]       diff, unstable_reg;
    logic                      valid_reg, have_prev_reg;

    assign s_lvl      = start ^ start_inv;
    assign p_lvl      = stop ^ stop_inv;
    assign running    = (state_reg == RUN) || (state_reg == RUN_W);
    assign window_end = clk_en && !rearm && (state_reg == RUN) && p_lvl;
    assign cnt_inc    = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // rearm overrides the gate FSM on every clock, enabled or not
    always_comb begin
        state_next = state_reg;
        if (rearm) begin
            state_next = IDLE;
        end else if (clk_en) begin
            case (state_reg)
                IDLE:    if (!s_lvl) state_next = ARMED;
                ARMED:   if (s_lvl) state_next = p_lvl ? RUN_W : RUN;
                RUN_W:   if (!p_lvl) state_next = RUN;
                RUN:     if (p_lvl) state_next = hold ? HELD : (s_lvl ? IDLE : ARMED);
                HELD:    state_next = HELD;
                default: state_next = IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] word;
            assign word = lfsr_reg[gi*WIDTH +: WIDTH];
            assign lfsr_shift[gi*WIDTH +: WIDTH] = {word[WIDTH-2:0], data[gi] ^ (^(word & TAPS))};
            assign diff[gi] = lfsr_shift[gi*WIDTH +: WIDTH] != sig_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_reg      <= '0;
            cnt_reg       <= '0;
            sig_reg       <= '0;
            count_reg     <= '0;
            unstable_reg  <= '0;
            valid_reg     <= 1'b0;
            have_prev_reg <= 1'b0;
        end else begin
            valid_reg <= window_end;
            // Words and counter sit at zero outside the window, so entry starts clean
            if (rearm || !running) begin
                lfsr_reg <= '0;
                cnt_reg  <= '0;
            end else if (clk_en) begin
                lfsr_reg <= lfsr_shift;
                cnt_reg  <= cnt_inc;
            end
            if (rearm) begin
                have_prev_reg <= 1'b0;
            end else if (window_end) begin
                sig_reg       <= lfsr_shift;
                count_reg     <= cnt_inc;
                unstable_reg  <= have_prev_reg ? diff : '0;
                have_prev_reg <= 1'b1;
            end
        end
    end

    assign signature = sig_reg;
    assign count     = count_reg;
    assign valid     = valid_reg;
    assign unstable  = unstable_reg;
    assign gate      = running;

endmodule

// File: tb/tb_sigan_multi.sv
// Scoreboard bench for sigan_multi: directed windows push expected captures, monitors pop on valid.
// A second instance with a 3-bit counter covers counter saturation.
module tb_sigan_multi;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en_a = 1'b0, clk_en_b = 1'b0;
    logic        start = 1'b0, stop = 1'b0, start_inv = 1'b0, stop_inv = 1'b0;
    logic        hold = 1'b0, rearm = 1'b0;
    logic [3:0]  data = 4'b0000;

    logic [63:0] sig_a, sig_b;
    logic [15:0] cnt_a;
    logic [2:0]  cnt_b;
    logic        valid_a, valid_b, gate_a, gate_b;
    logic [3:0]  unst_a, unst_b;

    typedef struct {
        logic [63:0] sig;
        logic [15:0] cnt;
        logic [3:0]  unst;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   tests = 0;
    int   fails = 0;
    int   en_sel = 0;

    always #5 clock = ~clock;

    sigan_multi dut_a (
        .clock(clock), .reset(reset), .clk_en(clk_en_a), .start(start), .stop(stop),
        .start_inv(start_inv), .stop_inv(stop_inv), .hold(hold), .rearm(rearm), .data(data),
        .signature(sig_a), .count(cnt_a), .valid(valid_a), .unstable(unst_a), .gate(gate_a)
    );

    sigan_multi #(.CNT_W(3)) dut_b (
        .clock(clock), .reset(reset), .clk_en(clk_en_b), .start(start), .stop(stop),
        .start_inv(start_inv), .stop_inv(stop_inv), .hold(hold), .rearm(rearm), .data(data),
        .signature(sig_b), .count(cnt_b), .valid(valid_b), .unstable(unst_b), .gate(gate_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sg(input logic [15:0] c0, input logic [15:0] c1,
                                       input logic [15:0] c2, input logic [15:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic sel_gate();
        return (en_sel == 0) ? gate_a : gate_b;
    endfunction

    function automatic logic sel_valid();
        return (en_sel == 0) ? valid_a : valid_b;
    endfunction

    // One enabled edge with logical levels st/sp, preceded by gap disabled cycles
    // during which data and stop are driven to misleading values.
    task automatic en_edge(input int gap, input logic [3:0] d, input logic st, input logic sp);
        for (int i = 0; i < gap; i++) begin
            clk_en_a = 1'b0;
            clk_en_b = 1'b0;
            data = ~d;
            stop = ~(sp ^ stop_inv);
            @(posedge clock); #1;
        end
        data  = d;
        start = st ^ start_inv;
        stop  = sp ^ stop_inv;
        clk_en_a = (en_sel == 0);
        clk_en_b = (en_sel == 1);
        @(posedge clock); #1;
        clk_en_a = 1'b0;
        clk_en_b = 1'b0;
    endtask

    // Start-to-stop window of n shift edges; d_last is the data on the ending edge.
    task automatic run_window(input int n, input int gap, input logic [3:0] d,
                              input logic [3:0] d_last, input logic hld, input logic rearm_end,
                              input logic [63:0] e_sig, input logic [15:0] e_cnt,
                              input logic [3:0] e_unst);
        exp_t e;
        hold = hld;
        en_edge(gap, d, 1'b0, 1'b0);
        en_edge(gap, d, 1'b1, 1'b0);
        chk("gate_in_run", 64'(sel_gate()), 64'(1));
        for (int i = 1; i < n; i++) en_edge(gap, d, 1'b1, 1'b0);
        if (rearm_end) begin
            rearm = 1'b1;
        end else begin
            e.sig = e_sig; e.cnt = e_cnt; e.unst = e_unst;
            if (en_sel == 0) q_a.push_back(e);
            else             q_b.push_back(e);
        end
        en_edge(rearm_end ? 0 : gap, d_last, 1'b1, 1'b1);
        rearm = 1'b0;
        chk("valid_after_end", 64'(sel_valid()), 64'(!rearm_end));
        chk("gate_after_end", 64'(sel_gate()), 64'(0));
        start = start_inv;
        stop  = stop_inv;
    endtask

    task automatic pulse_rearm();
        rearm = 1'b1;
        @(posedge clock); #1;
        rearm = 1'b0;
    endtask

    always @(negedge clock) begin : mon_a
        exp_t e;
        if (valid_a) begin
            if (q_a.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_valid_a: valid=1 with no capture expected, sig=%h", sig_a);
            end else begin
                e = q_a.pop_front();
                $display("[TB] dut_a capture sig=%h cnt=%0d unst=%b", sig_a, cnt_a, unst_a);
                chk("sig_a", sig_a, e.sig);
                chk("cnt_a", 64'(cnt_a), 64'(e.cnt));
                chk("unst_a", 64'(unst_a), 64'(e.unst));
            end
        end
    end

    always @(negedge clock) begin : mon_b
        exp_t e;
        if (valid_b) begin
            if (q_b.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_valid_b: valid=1 with no capture expected, sig=%h", sig_b);
            end else begin
                e = q_b.pop_front();
                $display("[TB] dut_b capture sig=%h cnt=%0d unst=%b", sig_b, cnt_b, unst_b);
                chk("sig_b", sig_b, e.sig);
                chk("cnt_b", 64'(cnt_b), 64'(e.cnt[2:0]));
                chk("unst_b", 64'(unst_b), 64'(e.unst));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_sig", sig_a, 64'(0));
        chk("rst_cnt", 64'(cnt_a), 64'(0));
        chk("rst_valid", 64'(valid_a), 64'(0));
        chk("rst_unst", 64'(unst_a), 64'(0));
        chk("rst_gate", 64'(gate_a), 64'(0));
        reset = 1'b0;
        @(posedge clock); #1;

        // 7-shift and 1-shift windows on channel 0
        run_window(7, 0, 4'b0001, 4'b0001, 1'b0, 1'b0, sg(16'h007F, 0, 0, 0), 16'd7, 4'b0000);
        run_window(1, 0, 4'b0001, 4'b0001, 1'b0, 1'b0, sg(16'h0001, 0, 0, 0), 16'd1, 4'b0001);

        // start and stop together from ARMED: RUN_W until stop is seen low
        begin
            exp_t e;
            en_edge(0, 4'b0001, 1'b0, 1'b0);
            en_edge(0, 4'b0001, 1'b1, 1'b1);
            chk("gate_run_w", 64'(gate_a), 64'(1));
            en_edge(0, 4'b0001, 1'b1, 1'b1);
            en_edge(0, 4'b0001, 1'b1, 1'b1);
            chk("run_w_no_capture", 64'(valid_a), 64'(0));
            chk("run_w_gate_held", 64'(gate_a), 64'(1));
            en_edge(0, 4'b0001, 1'b1, 1'b0);
            e.sig = sg(16'h000F, 0, 0, 0); e.cnt = 16'd4; e.unst = 4'b0001;
            q_a.push_back(e);
            en_edge(0, 4'b0001, 1'b1, 1'b1);
            chk("run_w_valid", 64'(valid_a), 64'(1));
            start = 1'b0; stop = 1'b0;
        end

        // asynchronous reset in the middle of a window with data toggling
        en_edge(0, 4'b0001, 1'b0, 1'b0);
        en_edge(0, 4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) en_edge(0, (i % 2 == 1) ? 4'b1111 : 4'b0101, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_sig", sig_a, 64'(0));
        chk("async_rst_cnt", 64'(cnt_a), 64'(0));
        chk("async_rst_unst", 64'(unst_a), 64'(0));
        chk("async_rst_gate", 64'(gate_a), 64'(0));
        start = 1'b0; stop = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        run_window(7, 0, 4'b0001, 4'b0001, 1'b0, 1'b0, sg(16'h007F, 0, 0, 0), 16'd7, 4'b0000);

        // rearm keeps results but clears have_prev
        pulse_rearm();
        chk("rearm_keeps_sig", sig_a, sg(16'h007F, 0, 0, 0));
        chk("rearm_keeps_cnt", 64'(cnt_a), 64'(7));

        // unstable: two identical windows then data[2] flipped once
        run_window(3, 0, 4'b0000, 4'b0000, 1'b0, 1'b0, sg(0, 0, 0, 0), 16'd3, 4'b0000);
        run_window(3, 0, 4'b0000, 4'b0000, 1'b0, 1'b0, sg(0, 0, 0, 0), 16'd3, 4'b0000);
        run_window(3, 0, 4'b0000, 4'b0100, 1'b0, 1'b0, sg(0, 0, 16'h0001, 0), 16'd3, 4'b0100);

        // single-shot hold: frozen in HELD until rearm
        run_window(3, 0, 4'b0001, 4'b0001, 1'b1, 1'b0, sg(16'h0007, 0, 0, 0), 16'd3, 4'b0101);
        en_edge(0, 4'b0010, 1'b0, 1'b0);
        en_edge(0, 4'b0010, 1'b1, 1'b0);
        en_edge(0, 4'b0010, 1'b1, 1'b1);
        en_edge(0, 4'b0010, 1'b1, 1'b0);
        chk("held_gate", 64'(gate_a), 64'(0));
        chk("held_sig", sig_a, sg(16'h0007, 0, 0, 0));
        start = 1'b0; stop = 1'b0; hold = 1'b0;
        pulse_rearm();
        run_window(2, 0, 4'b0010, 4'b0010, 1'b0, 1'b0, sg(0, 16'h0003, 0, 0), 16'd2, 4'b0000);

        // ending edge coincides with rearm: no capture
        run_window(3, 0, 4'b0001, 4'b0001, 1'b0, 1'b1, 64'(0), 16'd0, 4'b0000);
        chk("rearm_end_sig_kept", sig_a, sg(0, 16'h0003, 0, 0));

        // clk_en 1-in-3 window equals a continuous one; then inverted qualifiers
        run_window(5, 2, 4'b0001, 4'b0001, 1'b0, 1'b0, sg(16'h001F, 0, 0, 0), 16'd5, 4'b0000);
        start_inv = 1'b1; stop_inv = 1'b1;
        start = 1'b1; stop = 1'b1;
        run_window(5, 0, 4'b0001, 4'b0001, 1'b0, 1'b0, sg(16'h001F, 0, 0, 0), 16'd5, 4'b0000);
        start_inv = 1'b0; stop_inv = 1'b0;
        start = 1'b0; stop = 1'b0;

        // 3-bit counter instance: gapped 5-shift window, then saturating 10-shift window
        en_sel = 1;
        run_window(5, 2, 4'b0001, 4'b0001, 1'b0, 1'b0, sg(16'h001F, 0, 0, 0), 16'd5, 4'b0000);
        run_window(10, 0, 4'b0001, 4'b0001, 1'b0, 1'b0, sg(16'h03F9, 0, 0, 0), 16'd7, 4'b0001);

        repeat (3) @(posedge clock);
        #6;
        chk("pending_a", 64'(q_a.size()), 64'(0));
        chk("pending_b", 64'(q_b.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sigan_multi.md
Name: sigan_multi

Overview:
Parametrised multi-channel successor to the HP5004-style signature analyzer. One start/stop gate state machine, with polarity-selectable qualifiers and a clock enable, controls CHANNELS parallel LFSR compressors. Each window end produces one signature per channel, a window clock count, a valid pulse and a per-channel unstable flag. Single-shot hold mode freezes results until a rearm. Sits between the probe input synchronisers and the display/readout register block.

Parameters:
WIDTH, 16, LFSR/signature width per channel (>=8)
TAPS, 16'h8940, feedback tap mask over word bits [WIDTH-1:0] (default taps 6,8,11,15)
CHANNELS, 4, number of data inputs/compressors (>=1)
CNT_W, 16, width of window clock counter

Ports:
clock  in  1  system clock, all state changes on rising edge
reset  in  1  asynchronous, active-high
clk_en  in  1  qualified probe-clock strobe; FSM/LFSR/counter advance only when high
start  in  1  start qualifier (level)
stop  in  1  stop qualifier (level)
start_inv  in  1  1 = start active-low
stop_inv  in  1  1 = stop active-low
hold  in  1  1 = single-shot: freeze after one window
rearm  in  1  one-cycle pulse: leave HELD / restart measurement
data  in  CHANNELS  probe data, bit c feeds channel c
signature  out  CHANNELS*WIDTH  captured signatures, channel c at [c*WIDTH +: WIDTH]
count  out  CNT_W  shift edges in last captured window, saturating
valid  out  1  one-cycle pulse: new signature/count captured
unstable  out  CHANNELS  bit c = last signature of channel c differs from previous one
gate  out  1  high in RUN or RUN_W

Behaviour:
- Reset is the only asynchronous event.
- Reset state: FSM=IDLE; all LFSR words, signature, count and unstable are 0; valid=0; have_prev=0.
- Qualified levels: s = start ^ start_inv, p = stop ^ stop_inv. Sampled only on edges with clk_en=1.
- FSM (states IDLE, ARMED, RUN_W, RUN, HELD), evaluated on clk_en edges:
  - IDLE: s=0 -> ARMED.
  - ARMED: s=1,p=0 -> RUN; s=1,p=1 -> RUN_W; else stay.
  - RUN_W: p=0 -> RUN. Stop must be seen inactive before it can end the window.
  - RUN: p=0 -> stay. p=1 ends the window:
    - hold=1 -> HELD;
    - hold=0 and s=1 -> IDLE;
    - hold=0 and s=0 -> ARMED.
  - HELD: stays until rearm.
- rearm is sampled every clock, regardless of clk_en, and has priority over the FSM.
  - Forces IDLE, clears LFSRs and the working counter, clears have_prev.
  - signature, count and unstable are kept.
- LFSR per channel: held at 0 outside RUN/RUN_W.
  - On each clk_en edge in RUN or RUN_W: word <= {word[WIDTH-2:0], data[c] ^ ^(word & TAPS)}.
  - The edge that enters RUN/RUN_W does not shift.
  - The edge that ends the window (p=1 in RUN) does shift.
- Working counter: counts shift edges and saturates at all ones. Cleared on window entry.
- Capture happens on the window-ending edge:
  - signature <= post-shift words; count <= post-increment count; valid=1 for exactly the next cycle.
  - unstable[c] <= have_prev & (new != old signature c); then have_prev <= 1.
- clk_en=0: FSM, LFSRs and counter frozen; no capture.
- Window-ending edge coinciding with rearm: rearm wins and there is no capture.
- Counter at saturation: stays at 2^CNT_W-1; LFSR continues shifting.

Test Plan:
- Reset mid-RUN with data toggling -> all outputs 0 immediately (asynchronous), FSM IDLE; next window behaves normally.
- start_inv=stop_inv=0, data[0]=1, other channels 0: start rises, 7 clk_en edges in RUN, stop on the 7th -> sig ch0=0x007F, ch1..3=0x0000, count=7, one valid pulse.
- Same window but 1 shift edge -> ch0=0x0001, count=1; start and stop high together from ARMED -> RUN_W; no capture until stop drops then rises again.
- Two identical windows, then a third with data[2] flipped once -> unstable stays 0000 after windows 1-2, becomes 0100 after window 3.
- hold=1: after capture FSM is HELD; further start/stop activity changes nothing; rearm -> IDLE; next window captures and unstable=0 because have_prev was cleared.
- clk_en toggling 1-in-3 during a 5-shift window, plus CNT_W=3 override with a 10-shift window -> result identical to the 5-shift continuous window; count saturates at 7.
